// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register, 1-cycle latency, Flush inserts a bubble, saturating stall counter.
// Back-pressure: In_Ready = !Out_Valid || Out_Ready; define PIPE_STAGE_SKID_EN for a skid entry and a registered In_Ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_vld;
  logic [DATA_W-1:0] main_dat;
  logic [CNT_W-1:0]  stall_cnt;
  logic              accept;
  logic              emit;
  logic              stall;

  assign accept = In_Valid && In_Ready;
  assign emit   = main_vld && Out_Ready;
  assign stall  = main_vld && !Out_Ready;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t            state;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_dat;

  // Readiness comes only from the skid flag, so Out_Ready never reaches In_Ready.
  assign In_Ready = !skid_vld;

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      state    <= ST_EMPTY;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= BUBBLE_VAL;
      skid_dat <= BUBBLE_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_dat <= In_Data;
            main_vld <= 1'b1;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_dat <= In_Data;
          end else if (accept) begin
            skid_dat <= In_Data;
            skid_vld <= 1'b1;
            state    <= ST_TWO;
          end else if (emit) begin
            main_vld <= 1'b0;
            state    <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Older beat already sits in main; skid refills it to keep FIFO order.
          if (emit) begin
            main_dat <= skid_dat;
            skid_vld <= 1'b0;
            state    <= ST_ONE;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          main_vld <= 1'b0;
          skid_vld <= 1'b0;
        end
      endcase
    end
  end
`else
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t state;

  assign In_Ready = !main_vld || Out_Ready;

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      state    <= ST_EMPTY;
      main_vld <= 1'b0;
      main_dat <= BUBBLE_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_dat <= In_Data;
            main_vld <= 1'b1;
            state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          // Accept while full implies emit, since In_Ready then requires Out_Ready.
          if (accept) begin
            main_dat <= In_Data;
          end else if (emit) begin
            main_vld <= 1'b0;
            state    <= ST_EMPTY;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          main_vld <= 1'b0;
        end
      endcase
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (!Flush && stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign Out_Valid = main_vld;
  assign Out_Data  = main_dat;
  assign Stall_Cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam logic [31:0] BUB = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, Flush, In_Valid, Out_Ready;
  logic [31:0] In_Data;
  wire         In_Ready, Out_Valid;
  wire  [31:0] Out_Data;
  wire  [15:0] Stall_Cnt;

  logic        Reset3 = 1'b1, In_Valid3 = 1'b0, Out_Ready3 = 1'b0;
  logic [7:0]  In_Data3 = 8'h00;
  wire         In_Ready3, Out_Valid3;
  wire  [7:0]  Out_Data3;
  wire  [2:0]  Stall_Cnt3;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Data(In_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Stall_Cnt(Stall_Cnt));

  pipe_stage_reg #(.DATA_W(8), .BUBBLE_VAL(8'h00), .CNT_W(3)) dut3 (
    .Clk(Clk), .Reset(Reset3), .Flush(1'b0), .In_Valid(In_Valid3), .In_Ready(In_Ready3),
    .In_Data(In_Data3), .Out_Valid(Out_Valid3), .Out_Ready(Out_Ready3), .Out_Data(Out_Data3),
    .Stall_Cnt(Stall_Cnt3));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the stage is a FIFO of capacity 1 (or 2 with skid).
  logic [31:0] mq[$];
  logic [31:0] m_hold = BUB;
  int          m_cnt  = 0;

  function automatic bit m_in_rdy();
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || (Out_Ready == 1'b1);
  endfunction

  task automatic set_in(input bit rst, input bit fl, input bit iv, input logic [31:0] d, input bit ordy);
    Reset = rst; Flush = fl; In_Valid = iv; In_Data = d; Out_Ready = ordy;
    #1;
  endtask

  task automatic edge_step();
    bit acc, emt;
    @(posedge Clk);
    acc = In_Valid && m_in_rdy();
    emt = (mq.size() > 0) && Out_Ready;
    if (Reset) begin
      mq.delete(); m_hold = BUB; m_cnt = 0;
    end else if (Flush) begin
      mq.delete(); m_hold = BUB;
    end else begin
      if ((mq.size() > 0) && !Out_Ready && (m_cnt < 65535)) m_cnt++;
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back(In_Data);
      if (mq.size() > 0) m_hold = mq[0];
    end
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 0, 1, $urandom, 1); edge_step();
    set_in(1, 0, 0, 0, 0);        edge_step();
    set_in(0, 0, 0, 0, 1);
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", Out_Valid); end
    n_vec++; if (Out_Data !== BUB) begin n_err++; $display("FAIL reset_out_data: got %h want %h", Out_Data, BUB); end
    n_vec++; if (Stall_Cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", Stall_Cnt); end
    n_vec++; if (In_Ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", In_Ready); end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 0, 1, 32'(k), 1);
      n_vec++; if (In_Ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, In_Ready); end
      edge_step();
      n_vec++; if (Out_Valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, Out_Valid); end
      n_vec++; if (Out_Data !== 32'(k)) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", k, Out_Data, k); end
      n_vec++; if (Stall_Cnt !== 16'd0) begin n_err++; $display("FAIL stream_cnt[%0d]: got %0d want 0", k, Stall_Cnt); end
    end
    set_in(0, 0, 0, 0, 1); edge_step();
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", Out_Valid); end
    n_vec++; if (Out_Data !== 32'd4) begin n_err++; $display("FAIL drain_data_hold: got %h want 4", Out_Data); end
  endtask

  task automatic test_stall();
    bit exp_rdy;
    set_in(0, 0, 1, 32'hA5A5A5A5, 1); edge_step();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, 32'h5A5A5A5A, 0);
      exp_rdy = SKID && (i == 0);
      n_vec++; if (In_Ready !== exp_rdy) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want %b", i, In_Ready, exp_rdy); end
      edge_step();
      n_vec++; if (Out_Data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL stall_data[%0d]: got %h want a5a5a5a5", i, Out_Data); end
      n_vec++; if (Out_Valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, Out_Valid); end
      n_vec++; if (Stall_Cnt !== 16'(i + 1)) begin n_err++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, Stall_Cnt, i + 1); end
    end
    set_in(0, 0, 1, 32'h5A5A5A5A, 1); edge_step();
    n_vec++; if (Out_Valid !== 1'b1) begin n_err++; $display("FAIL stall_order_valid: got %b want 1", Out_Valid); end
    n_vec++; if (Out_Data !== 32'h5A5A5A5A) begin n_err++; $display("FAIL stall_order_data: got %h want 5a5a5a5a", Out_Data); end
    set_in(0, 0, 0, 0, 1); edge_step();
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL stall_drain_valid: got %b want 0", Out_Valid); end
    n_vec++; if (Stall_Cnt !== 16'd5) begin n_err++; $display("FAIL stall_cnt_final: got %0d want 5", Stall_Cnt); end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    set_in(0, 0, 1, 32'h11, 0); edge_step();
    if (SKID) begin set_in(0, 0, 1, 32'h22, 0); edge_step(); end
    cnt_before = 16'(m_cnt);
    set_in(0, 1, 1, 32'h77, 0); edge_step();
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", Out_Valid); end
    n_vec++; if (Out_Data !== BUB) begin n_err++; $display("FAIL flush_data: got %h want %h", Out_Data, BUB); end
    n_vec++; if (Stall_Cnt !== cnt_before) begin n_err++; $display("FAIL flush_cnt_held: got %0d want %0d", Stall_Cnt, cnt_before); end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1); edge_step();
      n_vec++; if (Out_Valid !== 1'b0 || Out_Data !== BUB) begin
        n_err++; $display("FAIL flush_no_ghost[%0d]: got vld=%b data=%h want vld=0 data=%h", i, Out_Valid, Out_Data, BUB);
      end
    end
  endtask

  task automatic test_reset_full();
    set_in(0, 0, 1, 32'h31, 0); edge_step();
    set_in(0, 0, 1, 32'h32, 0); edge_step();
    set_in(1, 0, 1, 32'h99, 0); edge_step();
    set_in(0, 0, 0, 0, 0);
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL rstfull_valid: got %b want 0", Out_Valid); end
    n_vec++; if (In_Ready !== 1'b1) begin n_err++; $display("FAIL rstfull_in_ready: got %b want 1", In_Ready); end
    n_vec++; if (Out_Data !== BUB) begin n_err++; $display("FAIL rstfull_data: got %h want %h", Out_Data, BUB); end
    n_vec++; if (Stall_Cnt !== 16'd0) begin n_err++; $display("FAIL rstfull_cnt: got %0d want 0", Stall_Cnt); end
  endtask

  task automatic test_saturate();
    int exp;
    @(posedge Clk); #1;
    Reset3 = 1'b0; In_Valid3 = 1'b1; In_Data3 = 8'h3C; Out_Ready3 = 1'b0;
    @(posedge Clk); #1;
    In_Valid3 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); #1;
      exp = (k < 7) ? k : 7;
      n_vec++; if (Stall_Cnt3 !== 3'(exp)) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, Stall_Cnt3, exp); end
      n_vec++; if (Out_Data3 !== 8'h3C) begin n_err++; $display("FAIL sat_data[%0d]: got %h want 3c", k, Out_Data3); end
    end
    Reset3 = 1'b1;
    @(posedge Clk); #1;
    n_vec++; if (Stall_Cnt3 !== 3'd0) begin n_err++; $display("FAIL sat_reset_cnt: got %0d want 0", Stall_Cnt3); end
    n_vec++; if (Out_Valid3 !== 1'b0) begin n_err++; $display("FAIL sat_reset_valid: got %b want 0", Out_Valid3); end
  endtask

  task automatic test_random();
    bit r, f, iv, ordy;
    for (int c = 0; c < 10000; c++) begin
      r    = ($urandom_range(0, 999) == 0);
      f    = ($urandom_range(0, 149) == 0);
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ((c / 64) % 4 == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      set_in(r, f, iv, $urandom, ordy);
      n_vec++; if (In_Ready !== m_in_rdy()) begin n_err++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, In_Ready, m_in_rdy()); end
`ifdef PIPE_STAGE_SKID_EN
      Out_Ready = !ordy; #1;
      n_vec++; if (In_Ready !== m_in_rdy()) begin n_err++; $display("FAIL rand_rdy_comb[%0d]: got %b want %b", c, In_Ready, m_in_rdy()); end
      Out_Ready = ordy; #1;
`endif
      edge_step();
      n_vec++; if (Out_Valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", c, Out_Valid, mq.size() > 0); end
      n_vec++; if (Out_Data !== m_hold) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", c, Out_Data, m_hold); end
      n_vec++; if (Stall_Cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, Stall_Cnt, m_cnt); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 3000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_full();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
